// File: rtl/blinker_array_pkg.sv
// Shared definitions for the multi-channel LED blinker: LED pair type,
// PWM counter width and the 2-bit LED up-count step.
package blinker_array_pkg;

  localparam int LED_PER_CH = 2;
  localparam int PWM_W      = 4;

  typedef logic [LED_PER_CH-1:0] led_pair_t;

  // Bit 0 toggles every step; bit 1 toggles when bit 0 was set (binary up-count).
  function automatic led_pair_t led_step(input led_pair_t s);
    return {s[1] ^ s[0], ~s[0]};
  endfunction

endpackage

// File: rtl/blinker_array_ch.sv
// One blinker channel: tick counter compared against a live divide value,
// stepping a 2-bit LED counter each time the count reaches the divide.
module blinker_array_ch
  import blinker_array_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick,
  input  logic [DIV_W-1:0] div_i,
  output led_pair_t        led_state
);

  logic [DIV_W-1:0] cnt;

  // >= rather than == so a divide lowered below the running count wraps on
  // the next tick instead of running the counter all the way round.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      led_state <= '0;
    end else if (en && tick) begin
      if (cnt >= div_i) begin
        cnt       <= '0;
        led_state <= led_step(led_state);
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/blinker_array.sv
// Multi-channel LED blinker: shared prescaler feeding N_CH divide channels.
// Optional PWM dimming of the LED outputs when BLINKER_ARRAY_PWM_EN is defined.
module blinker_array
  import blinker_array_pkg::*;
#(
  parameter int N_CH       = 6,
  parameter int DIV_W      = 8,
  parameter int PRESCALE   = 1,
  parameter int PRESCALE_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [N_CH*DIV_W-1:0]        div,
`ifdef BLINKER_ARRAY_PWM_EN
  input  logic [PWM_W-1:0]             duty,
`endif
  output logic                         tick,
  output logic [LED_PER_CH*N_CH-1:0]   led
);

  localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0]       pre_cnt;
  logic [LED_PER_CH*N_CH-1:0]  led_state;

  // With PRESCALE=1 PRE_LAST is 0, so every enabled cycle is a wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (!en) begin
      tick <= 1'b0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + PRESCALE_W'(1);
      tick    <= 1'b0;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    blinker_array_ch #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .tick      (tick),
      .div_i     (div[i*DIV_W +: DIV_W]),
      .led_state (led_state[i*LED_PER_CH +: LED_PER_CH])
    );
  end

`ifdef BLINKER_ARRAY_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;

  // PWM counter runs independently of en so a frozen pattern stays dimmed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      led     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      led     <= led_state & {(LED_PER_CH*N_CH){pwm_cnt < duty}};
    end
  end
`else
  assign led = led_state;
`endif

endmodule

// File: tb/tb_blinker_array.sv
// Directed bench for blinker_array: one PRESCALE=4 and one PRESCALE=1 instance
// on a shared clock, reset and enable, with table vectors and step scoreboard.
module tb_blinker_array;
  import blinker_array_pkg::*;

  localparam int N_CH  = 6;
  localparam int DIV_W = 8;
  localparam int LW    = LED_PER_CH * N_CH;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic [N_CH*DIV_W-1:0] div_a, div_b;
  logic                  tick_a, tick_b;
  logic [LW-1:0]         led_a, led_b;
`ifdef BLINKER_ARRAY_PWM_EN
  logic [PWM_W-1:0]      duty;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic      exp_tick;
    led_pair_t exp_pair;
  } vec_t;
  vec_t vecs[17];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  blinker_array #(.N_CH(N_CH), .DIV_W(DIV_W), .PRESCALE(4), .PRESCALE_W(16)) u_dut_a (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .div  (div_a),
`ifdef BLINKER_ARRAY_PWM_EN
    .duty (duty),
`endif
    .tick (tick_a),
    .led  (led_a)
  );

  blinker_array #(.N_CH(N_CH), .DIV_W(DIV_W), .PRESCALE(1), .PRESCALE_W(16)) u_dut_b (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .div  (div_b),
`ifdef BLINKER_ARRAY_PWM_EN
    .duty (duty),
`endif
    .tick (tick_b),
    .led  (led_b)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N_CH*DIV_W-1:0] div_all(input logic [DIV_W-1:0] d);
    return {N_CH{d}};
  endfunction

  function automatic logic [LW-1:0] rep_pair(input led_pair_t p);
    return {N_CH{p}};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    led_pair_t prev;
    int        on0, on1, on_all;

    rst   = 1'b1;
    en    = 1'b1;
    div_a = div_all(8'd0);
    div_b = div_all(8'd0);
`ifdef BLINKER_ARRAY_PWM_EN
    duty  = 4'd4;
`else
    div_b[0*DIV_W +: DIV_W] = 8'd2;
    div_b[1*DIV_W +: DIV_W] = 8'd5;
    div_b[3*DIV_W +: DIV_W] = 8'd1;
`endif

    // Reset held three cycles with en high.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_tick_a", tick_a, 0);
      check("rst_led_a",  led_a,  0);
      check("rst_tick_b", tick_b, 0);
      check("rst_led_b",  led_b,  0);
    end
    rst = 1'b0;

`ifndef BLINKER_ARRAY_PWM_EN
    // PRESCALE=4, div=0: ticks at 4,8,12,16; pairs step one cycle after each.
    vecs = '{
      '{1'b0, 2'b00}, '{1'b0, 2'b00}, '{1'b0, 2'b00}, '{1'b1, 2'b00},
      '{1'b0, 2'b01}, '{1'b0, 2'b01}, '{1'b0, 2'b01}, '{1'b1, 2'b01},
      '{1'b0, 2'b10}, '{1'b0, 2'b10}, '{1'b0, 2'b10}, '{1'b1, 2'b10},
      '{1'b0, 2'b11}, '{1'b0, 2'b11}, '{1'b0, 2'b11}, '{1'b1, 2'b11},
      '{1'b0, 2'b00}
    };
    for (int i = 0; i < 17; i++) begin
      step();
      check("tbl_tick_a", tick_a, vecs[i].exp_tick);
      check("tbl_led_a",  led_a,  rep_pair(vecs[i].exp_pair));
      if (i == 0) begin
        check("first_tick_b", tick_b, 1);
        check("first_led_b",  led_b,  0);
      end
      if (i == 9) check("led_b_k10", led_b, 12'b01_01_00_01_01_11);
    end
    repeat (20) step();
    // 36 ticks seen: div 2 -> 12 steps, div 5 -> 6, div 0 -> 36, div 1 -> 18.
    check("led_b_k37", led_b, 12'b00_00_10_00_10_00);
    check("led_a_k37", led_a, rep_pair(2'b01));

    // Reset coinciding with tick high.
    check("tick_b_before_rst", tick_b, 1);
    rst = 1'b1;
    step();
    check("rst_tick_tick_a", tick_a, 0);
    check("rst_tick_led_a",  led_a,  0);
    check("rst_tick_tick_b", tick_b, 0);
    check("rst_tick_led_b",  led_b,  0);

    // Lowering div below the running count wraps on the next tick.
    div_b = div_all(8'd0);
    div_b[0 +: DIV_W] = 8'd200;
    rst = 1'b0;
    repeat (101) step();
    check("lower_before", led_b[1:0], 2'b00);
    div_b[0 +: DIV_W] = 8'd10;
    step();
    check("lower_wrap", led_b[1:0], 2'b01);
    repeat (10) step();
    check("lower_period_hold", led_b[1:0], 2'b01);
    step();
    check("lower_period_step", led_b[1:0], 2'b10);

    // Freeze: unfrozen steps at 13 and 25 shift to 20 and 32.
    rst   = 1'b1;
    div_a = div_all(8'd2);
    step();
    rst = 1'b0;
    exp_q.push_back(32'd20);
    exp_q.push_back(32'd32);
    prev = led_a[1:0];
    for (int e = 1; e <= 40; e++) begin
      en = !(e >= 7 && e <= 13);
      step();
      if (e >= 7 && e <= 13) begin
        check("freeze_tick", tick_a, 0);
        check("freeze_led",  led_a,  0);
      end
      if (e == 14) check("resume_tick_lo", tick_a, 0);
      if (e == 15) check("resume_tick_hi", tick_a, 1);
      if (led_a[1:0] != prev) begin
        if (exp_q.size() == 0) check("unexpected_step", e, 0);
        else check("step_edge", e, exp_q.pop_front());
        prev = led_a[1:0];
      end
    end
    en = 1'b1;
    check("steps_missing", exp_q.size(), 0);
`else
    step();
    check("first_tick_a", tick_a, 0);
    check("first_led_a",  led_a,  0);
    check("first_tick_b", tick_b, 1);
    check("first_led_b",  led_b,  0);
    // Edges 2..4 step every channel of the PRESCALE=1 instance to 11, then freeze.
    repeat (3) step();
    en = 1'b0;
    repeat (3) step();
    on0 = 0; on1 = 0; on_all = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      on0    += int'(led_b[0]);
      on1    += int'(led_b[1]);
      on_all += $countones(led_b);
    end
    check("pwm_duty4_bit0", on0, 4);
    check("pwm_duty4_bit1", on1, 4);
    check("pwm_duty4_all",  on_all, 4 * LW);
    duty = 4'd0;
    repeat (2) step();
    on_all = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      on_all += $countones(led_b);
    end
    check("pwm_duty0_all", on_all, 0);
    en = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/blinker_array.md
# blinker_array

Parametrised multi-channel LED blinker for the clocking feature tests. It runs a shared prescaler and N independent channels, each with a runtime divide value, on a single clock. Each channel drives a 2-bit binary LED counter. The block replaces per-clock ad-hoc blinkers when one fabric clock must show several distinct, software-selectable blink rates.

## Interface
- `N_CH`, 6: number of channels (1..16).
- `DIV_W`, 8: width of each channel's divide field.
- `PRESCALE`, 1: shared prescaler period in clk cycles (>=1).
- `PRESCALE_W`, 16: prescaler counter width; must hold `PRESCALE-1`.
- `clk`  in  1: single clock; all logic on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: global run enable; low freezes all state.
- `div`  in  N_CH*DIV_W: channel i's divide value in bits [i*DIV_W +: DIV_W].
- `tick`  out  1: registered prescaler strobe.
- `led`  out  2*N_CH: channel i's LED pair in bits [2i+1:2i].
- `duty`  in  4: PWM duty; present only with `BLINKER_ARRAY_PWM_EN`.

## Operation
- Reset: prescaler count, `tick`, every channel count, every LED state and the PWM counter go to 0. `led` = 0.
- Prescaler: when `en`=1, it counts 0..PRESCALE-1 and wraps. `tick` is registered high for exactly one cycle at each wrap. With `PRESCALE`=1, `tick` stays high every enabled cycle.
- Channel i, on an edge with `tick`=1 and `en`=1:
  - If `cnt_i >= div_i`, then `cnt_i` <= 0 and the LED pair steps: `led[2i]` toggles; `led[2i+1]` toggles iff `led[2i]` was 1 (2-bit up-count 00→01→10→11→00).
  - Otherwise `cnt_i` <= `cnt_i`+1.
- LED step period is (div_i+1)·PRESCALE cycles. `div_i`=0 steps on every tick.
- `div` is sampled live; there is no shadow register.
  - Lowering `div_i` below the current `cnt_i` causes a wrap and step on the next tick (`>=` compare); the count never runs through 2^DIV_W.
  - Raising it extends the current period.
- `en`=0: prescaler, `tick` (forced 0), channel counts and LED state hold. Resuming continues from the held values; there is no restart.
- `rst` has priority over `en` and `tick` in the same cycle. Reset mid-period discards partial counts.
- Arithmetic is unsigned. Counters are DIV_W bits; the compare is DIV_W-bit unsigned.

## Timing
- After `rst` falls, `tick` first asserts PRESCALE cycles later, counted from the first edge with `rst`=0.
- Channel state updates on the edge that samples `tick`=1, so `led` changes 1 cycle after `tick` is seen high.
- Latency from `div` change to effect: next tick.
- No combinational path from any input to `led` or `tick`.

## Configuration
- `BLINKER_ARRAY_PWM_EN` defined:
  - Adds the `duty` port and a free-running 4-bit PWM counter, reset to 0 and advancing every cycle regardless of `en`.
  - Each `led` bit = LED state AND (pwm_cnt < `duty`), registered, adding 1 cycle of latency.
  - `duty`=0 keeps all LEDs dark; `duty`=15 lights them 15 of 16 cycles.
- Undefined: no `duty` port, no PWM counter; `led` = LED state directly.

## Structure
- Shared package `blinker_array_pkg`: `LED_PER_CH`=2, `PWM_W`=4, and a `led_pair_t` 2-bit typedef.
- One sub-module, `blinker_array_ch`: per-channel count, compare and 2-bit LED counter. Inputs are `clk`, `rst`, `en`, `tick` and `div_i`; it is instantiated N_CH times in a generate loop. The prescaler and PWM stay in the top.

## Test plan
- Reset: hold `rst` 3 cycles with `en`=1 → `led`=0 and `tick`=0 throughout and on the first cycle after release.
- `PRESCALE`=4, `div`=0 on all channels, `en`=1 → `tick` high at cycles 4, 8, 12… after release; each pair reads 01, 10, 11, 00 on the cycles after successive ticks.
- `PRESCALE`=1, channel 0 `div`=2, channel 1 `div`=5 → channel 0 steps every 3 cycles, channel 1 every 6 cycles; after 36 cycles the pairs read 00 and 10.
- Channel 0 `div`=200, let `cnt_0` reach 100, then set `div`=10 → step on the next tick and `cnt_0`=0; subsequent period is 11 ticks.
- Toggle `en` low for 7 cycles mid-period → `tick`, counts and `led` frozen; the step occurs exactly 7 cycles later than in a reference run. Also assert `rst` together with `tick`=1 → all zero the next cycle.
- With `BLINKER_ARRAY_PWM_EN`, LED state 11 and `duty`=4 → each bit high 4 of every 16 cycles. With `duty`=0 → `led` stays 0.
